// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit divider.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int MDU_DIV_WIDTH_DEFAULT = 32;

    // Bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_full;

    assign w_full = {i_rem, i_bit};
    assign o_qbit = (w_full >= {2'b00, i_dvs});
    assign o_rem  = o_qbit ? (w_full[WIDTH:0] - {1'b0, i_dvs}) : w_full[WIDTH:0];

endmodule

// File: rtl/mdu_divider.sv
// Iterative signed/unsigned restoring divider with annul support, latency WIDTH+2.
// Optional MDU_DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_q;

    assign w_accept  = start & ~annul;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_dvd_neg = signed_op & dividend[WIDTH-1];
    assign w_dvs_neg = signed_op & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // r_dq holds the dividend MSB-first and fills with quotient bits from the bottom.
    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_dvs  (r_dvs),
        .i_bit  (r_dq[WIDTH-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef MDU_DIV_ZERO_FAST_EN
                    w_next = (divisor == '0) ? DONE : CALC;
`else
                    w_next = CALC;
`endif
                end
            end
            CALC:    w_next = annul ? IDLE : (w_last ? FIX : CALC);
            FIX:     w_next = annul ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_dq    <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_cnt   <= '0;
`ifdef MDU_DIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_dq  <= {r_dq[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    // An annulled operation must leave the committed results untouched.
                    if (!annul) begin
                        r_quotient  <= r_neg_q ? (~r_dq + 1'b1) : r_dq;
                        r_remainder <= WIDTH'(r_neg_r ? (~r_rem + 1'b1) : r_rem);
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed self-checking bench for mdu_divider at WIDTH=32.
module tb_mdu_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors;
    int checks;
    int f;
    int n;
    int f2;
    int n2;

    mdu_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .annul     (annul),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle 1.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        signed_op = sg;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called at the negedge of cycle from_c; returns at the negedge of cycle to_c.
    task automatic watch(input int from_c, input int to_c, output int first, output int count);
        first = -1;
        count = 0;
        for (int c = from_c; c <= to_c; c++) begin
            if (c > from_c) @(negedge clk);
            if (done === 1'b1) begin
                count++;
                if (first < 0) first = c;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input logic [31:0] exp_q, input logic [31:0] exp_r);
        issue(sg, a, b);
        check({tag, " busy_c1"}, busy, 1'b1);
        watch(1, 35, f, n);
        check({tag, " done_cycle"}, f, exp_cyc);
        check({tag, " done_count"}, n, 1);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " busy_c35"}, busy, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        annul     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 32'h0);
        check("reset remainder", remainder, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u100div7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2);
        run_op("s-7div2", 1'b1, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_op("s7div-2", 1'b1, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD, 32'd1);
        run_op("smin_div-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'h0);
        run_op("umin_divmax", 1'b0, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000);

        // Annul in cycle 10, then restart in cycle 12.
        issue(1'b0, 32'd50, 32'd5);
        watch(1, 10, f, n);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul busy_c11", busy, 1'b0);
        check("annul no_done", n, 0);
        check("annul done_c11", done, 1'b0);
        check("annul quotient_held", quotient, 32'h0);
        check("annul remainder_held", remainder, 32'h80000000);
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd3);
        watch(1, 35, f, n);
        check("restart done_cycle", f + 12, 46);
        check("restart quotient", quotient, 32'd3);
        check("restart remainder", remainder, 32'd0);
        @(negedge clk);

        // start together with annul in IDLE is dropped.
        start     = 1'b1;
        annul     = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd7;
        @(negedge clk);
        start     = 1'b0;
        annul     = 1'b0;
        check("start_annul busy", busy, 1'b0);
        watch(1, 40, f, n);
        check("start_annul no_done", n, 0);
        check("start_annul quotient_held", quotient, 32'd3);

`ifdef MDU_DIV_ZERO_FAST_EN
        run_op("u5div0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5);
`else
        run_op("u5div0", 1'b0, 32'd5, 32'd0, 34, 32'hFFFFFFFF, 32'd5);
`endif

        // start pulsed in cycle 5 while busy must be ignored.
        issue(1'b0, 32'd100, 32'd7);
        watch(1, 4, f, n);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);
        start    = 1'b0;
        watch(6, 70, f2, n2);
        check("busy_start done_count", n + n2, 1);
        check("busy_start done_cycle", f2, 34);
        check("busy_start quotient", quotient, 32'd14);
        check("busy_start remainder", remainder, 32'd2);
        @(negedge clk);

        // Reset in cycle 20 aborts immediately.
        issue(1'b0, 32'd1000, 32'd10);
        watch(1, 19, f, n);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst quotient", quotient, 32'h0);
        check("midrst remainder", remainder, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        watch(21, 70, f2, n2);
        check("midrst no_done", n + n2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
